// File: rtl/rob_multi_commit_if.sv
`default_nettype none
// ============================================================================
//  Module      : rob_multi_commit_if
//  Description : Bundle of dispatch, issue-read, writeback, commit and erase
//                signals for the multi-commit reorder buffer.
//                master : the core side (decode/rename, FUs, commit stage)
//                slave  : the reorder buffer itself
//  Ports       : dispatch write (write_*), issue read (read_*),
//                two writeback ports (update_*_0/1), commit lanes (commit_*),
//                flush (erase_*), occupancy (count_out)
//  Revision    : 1.0 - initial release
// ============================================================================
interface rob_multi_commit_if #(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int EXC_W        = 8,
    parameter int COMMIT_WIDTH = 2
);
    // dispatch
    logic                             write_en;
    logic                             write_reg_write_en_in;
    logic [REG_ADDR_W-1:0]            write_reg_write_addr_in;
    logic                             write_is_delayslot_in;
    logic [31:0]                      write_pc_in;
    logic                             can_write;
    logic [ADDR_W-1:0]                write_rob_addr_out;
    // issue read
    logic                             read_en;
    logic                             can_read;
    logic [ADDR_W-1:0]                read_rob_addr_out;
    logic [31:0]                      read_pc_out;
    // writeback
    logic                             update_en_0;
    logic [ADDR_W-1:0]                update_addr_0;
    logic [DATA_W-1:0]                update_data_0;
    logic [EXC_W-1:0]                 update_exc_0;
    logic                             update_en_1;
    logic [ADDR_W-1:0]                update_addr_1;
    logic [DATA_W-1:0]                update_data_1;
    logic [EXC_W-1:0]                 update_exc_1;
    // commit
    logic                             commit_en;
    logic [1:0]                       commit_count_out;
    logic [COMMIT_WIDTH-1:0]          commit_valid_out;
    logic [COMMIT_WIDTH-1:0]          commit_reg_write_en_out;
    logic [COMMIT_WIDTH*REG_ADDR_W-1:0] commit_reg_write_addr_out;
    logic [COMMIT_WIDTH*DATA_W-1:0]   commit_reg_write_data_out;
    logic [COMMIT_WIDTH*EXC_W-1:0]    commit_exc_out;
    logic [COMMIT_WIDTH-1:0]          commit_is_delayslot_out;
    logic [COMMIT_WIDTH*32-1:0]       commit_pc_out;
    // flush and occupancy
    logic                             erase_en;
    logic [ADDR_W-1:0]                erase_from_addr;
    logic [ADDR_W:0]                  count_out;

    modport master (
        output write_en, write_reg_write_en_in, write_reg_write_addr_in,
               write_is_delayslot_in, write_pc_in, read_en,
               update_en_0, update_addr_0, update_data_0, update_exc_0,
               update_en_1, update_addr_1, update_data_1, update_exc_1,
               commit_en, erase_en, erase_from_addr,
        input  can_write, write_rob_addr_out, can_read, read_rob_addr_out,
               read_pc_out, commit_count_out, commit_valid_out,
               commit_reg_write_en_out, commit_reg_write_addr_out,
               commit_reg_write_data_out, commit_exc_out,
               commit_is_delayslot_out, commit_pc_out, count_out
    );

    modport slave (
        input  write_en, write_reg_write_en_in, write_reg_write_addr_in,
               write_is_delayslot_in, write_pc_in, read_en,
               update_en_0, update_addr_0, update_data_0, update_exc_0,
               update_en_1, update_addr_1, update_data_1, update_exc_1,
               commit_en, erase_en, erase_from_addr,
        output can_write, write_rob_addr_out, can_read, read_rob_addr_out,
               read_pc_out, commit_count_out, commit_valid_out,
               commit_reg_write_en_out, commit_reg_write_addr_out,
               commit_reg_write_data_out, commit_exc_out,
               commit_is_delayslot_out, commit_pc_out, count_out
    );
endinterface
`default_nettype wire

// File: rtl/rob_multi_commit.sv
`default_nettype none
// ============================================================================
//  Module      : rob_multi_commit
//  Description : Circular reorder buffer with one in-order dispatch write,
//                one in-order issue read, two out-of-order writeback ports,
//                up to COMMIT_WIDTH in-order commits and tail truncation.
//  Ports       : clk  - clock
//                rst  - synchronous reset, active low
//                bus  - rob_multi_commit_if.slave (all datapath signals)
//  Revision    : 1.0 - initial release
// ============================================================================
module rob_multi_commit #(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int EXC_W        = 8,
    parameter int COMMIT_WIDTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    rob_multi_commit_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int PW    = ADDR_W + 1;

    // Pointers carry a wrap bit so full and empty are distinguishable.
    logic [PW-1:0]          head_q, head_d, rd_q, rd_d, tail_q, tail_d;

    logic [31:0]            pc_q    [DEPTH];
    logic [DATA_W-1:0]      data_q  [DEPTH];
    logic [EXC_W-1:0]       exc_q   [DEPTH];
    logic [REG_ADDR_W-1:0]  waddr_q [DEPTH];
    logic [DEPTH-1:0]       done_q, we_q, ds_q;

    logic [PW-1:0]          w_count;
    logic                   w_full;
    logic [ADDR_W-1:0]      w_head_idx;
    logic [ADDR_W-1:0]      w_dist;
    logic                   w_write;
    logic [ADDR_W-1:0]      w_upd_off0, w_upd_off1;
    logic                   w_upd_ok0, w_upd_ok1;
    logic [ADDR_W-1:0]      w_lane_idx [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0] w_retire;
    logic [1:0]             w_ccount;
    logic                   w_chain;
    logic                   w_lane_ok;
    logic [PW-1:0]          w_rd_off;

    assign w_count    = tail_q - head_q;
    assign w_full     = (w_count == PW'(DEPTH));
    assign w_head_idx = head_q[ADDR_W-1:0];
    // Distance of the first discarded slot from head; 0 discards everything.
    assign w_dist     = bus.erase_from_addr - w_head_idx;
    assign w_write    = bus.write_en & ~w_full & ~bus.erase_en;

    // A writeback lands only on a slot that is live now and survives any erase.
    assign w_upd_off0 = bus.update_addr_0 - w_head_idx;
    assign w_upd_off1 = bus.update_addr_1 - w_head_idx;
    assign w_upd_ok0  = bus.update_en_0 && ({1'b0, w_upd_off0} < w_count)
                        && !(bus.erase_en && (w_upd_off0 >= w_dist));
    assign w_upd_ok1  = bus.update_en_1 && ({1'b0, w_upd_off1} < w_count)
                        && !(bus.erase_en && (w_upd_off1 >= w_dist));

    // Commit lanes: a lane retires only if every earlier lane retired cleanly,
    // so a faulting entry always retires alone in lane 0.
    always_comb begin
        w_retire  = '0;
        w_ccount  = '0;
        w_chain   = bus.commit_en;
        w_lane_ok = 1'b0;
        bus.commit_valid_out          = '0;
        bus.commit_reg_write_en_out   = '0;
        bus.commit_reg_write_addr_out = '0;
        bus.commit_reg_write_data_out = '0;
        bus.commit_exc_out            = '0;
        bus.commit_is_delayslot_out   = '0;
        bus.commit_pc_out             = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            w_lane_idx[i] = w_head_idx + ADDR_W'(i);
            w_lane_ok = (PW'(i) < w_count) && done_q[w_lane_idx[i]]
                        && (!bus.erase_en || (ADDR_W'(i) < w_dist));
            if ((i != 0) && (exc_q[w_lane_idx[i]] != '0))
                w_lane_ok = 1'b0;
            w_retire[i] = w_chain && w_lane_ok;
            w_chain     = w_retire[i] && (exc_q[w_lane_idx[i]] == '0);
            w_ccount    = w_ccount + {1'b0, w_retire[i]};

            bus.commit_valid_out[i]        = w_retire[i];
            bus.commit_reg_write_en_out[i] = we_q[w_lane_idx[i]];
            bus.commit_is_delayslot_out[i] = ds_q[w_lane_idx[i]];
            bus.commit_reg_write_addr_out[i*REG_ADDR_W +: REG_ADDR_W] = waddr_q[w_lane_idx[i]];
            bus.commit_reg_write_data_out[i*DATA_W +: DATA_W]         = data_q[w_lane_idx[i]];
            bus.commit_exc_out[i*EXC_W +: EXC_W]                      = exc_q[w_lane_idx[i]];
            bus.commit_pc_out[i*32 +: 32]                             = pc_q[w_lane_idx[i]];
        end
    end

    // Pointer next state. The read pointer is tracked as an offset from the
    // old head so erase clamping and commit dragging are simple compares.
    always_comb begin
        head_d = head_q + PW'(w_ccount);
        tail_d = tail_q;
        if (bus.erase_en)
            tail_d = head_q + PW'(w_dist);
        else if (w_write)
            tail_d = tail_q + PW'(1);

        w_rd_off = rd_q - head_q;
        if (bus.read_en && (rd_q != tail_q))
            w_rd_off = w_rd_off + PW'(1);
        if (bus.erase_en && (w_rd_off > {1'b0, w_dist}))
            w_rd_off = {1'b0, w_dist};
        if (w_rd_off < PW'(w_ccount))
            w_rd_off = PW'(w_ccount);
        rd_d = head_q + w_rd_off;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q <= '0;
            rd_q   <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            rd_q   <= rd_d;
            tail_q <= tail_d;
        end
    end

    // Entry storage. Commit clearing is last so it takes precedence.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                pc_q[s]    <= '0;
                data_q[s]  <= '0;
                exc_q[s]   <= '0;
                waddr_q[s] <= '0;
            end
            done_q <= '0;
            we_q   <= '0;
            ds_q   <= '0;
        end else begin
            if (w_write) begin
                pc_q[tail_q[ADDR_W-1:0]]    <= bus.write_pc_in;
                waddr_q[tail_q[ADDR_W-1:0]] <= bus.write_reg_write_addr_in;
                we_q[tail_q[ADDR_W-1:0]]    <= bus.write_reg_write_en_in;
                ds_q[tail_q[ADDR_W-1:0]]    <= bus.write_is_delayslot_in;
                data_q[tail_q[ADDR_W-1:0]]  <= '0;
                exc_q[tail_q[ADDR_W-1:0]]   <= '0;
                done_q[tail_q[ADDR_W-1:0]]  <= 1'b0;
            end
            if (w_upd_ok0) begin
                done_q[bus.update_addr_0] <= 1'b1;
                data_q[bus.update_addr_0] <= bus.update_data_0;
                exc_q[bus.update_addr_0]  <= bus.update_exc_0;
            end
            // Port 1 is applied after port 0 so it wins on a shared slot.
            if (w_upd_ok1) begin
                done_q[bus.update_addr_1] <= 1'b1;
                data_q[bus.update_addr_1] <= bus.update_data_1;
                exc_q[bus.update_addr_1]  <= bus.update_exc_1;
            end
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (w_retire[i])
                    done_q[w_lane_idx[i]] <= 1'b0;
            end
        end
    end

    assign bus.can_write          = ~w_full;
    assign bus.write_rob_addr_out = tail_q[ADDR_W-1:0];
    assign bus.can_read           = (rd_q != tail_q);
    assign bus.read_rob_addr_out  = rd_q[ADDR_W-1:0];
    assign bus.read_pc_out        = pc_q[rd_q[ADDR_W-1:0]];
    assign bus.commit_count_out   = w_ccount;
    assign bus.count_out          = w_count;

endmodule
`default_nettype wire
